// File: rtl/pe_group_feeder.sv
// pe_group_feeder
//   Holds one tile of weights (W), input activations (I) and partial-sum
//   seeds (O) in local register buffers and streams all three to the PE group
//   over independent valid/ready channels after a Start pulse.
//
// Ports:
//   clk, aclr                 clock, asynchronous active-high reset
//   Load_Valid/Load_Rdy       buffer write port. Load_Rdy is high only in IDLE.
//   Load_Sel/Load_Addr/Load_Data
//                             0=W, 1=I, 2=O, 3=ignored. An out-of-range address
//                             completes the handshake and writes nothing.
//   Start, Abort              start pulse (honoured in IDLE), synchronous abort
//   Busy, Done                Busy is high in SEND/DONE. Done is a one-cycle pulse.
//   {W,I,O}_DataOut*          output streams
//   Dbg_State                 current FSM state (0=IDLE, 1=SEND, 2=DONE)
//
// Handshake: a word transfers on any clock edge where Valid and Rdy are both
// high. Once Valid is raised, Valid and Data hold until that transfer.
// Valid never depends on Rdy.
module pe_group_feeder #(
    parameter int DataWidth = 32,
    parameter int W_Words   = 16,
    parameter int I_Words   = 19,
    parameter int O_Words   = 4,
    parameter int AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 Load_Valid,
    output logic                 Load_Rdy,
    input  logic [1:0]           Load_Sel,
    input  logic [AddrWidth-1:0] Load_Addr,
    input  logic [DataWidth-1:0] Load_Data,
    input  logic                 Start,
    input  logic                 Abort,
    output logic                 Busy,
    output logic                 Done,
    output logic                 W_DataOutValid,
    input  logic                 W_DataOutRdy,
    output logic [DataWidth-1:0] W_DataOut,
    output logic                 I_DataOutValid,
    input  logic                 I_DataOutRdy,
    output logic [DataWidth-1:0] I_DataOut,
    output logic                 O_DataOutValid,
    input  logic                 O_DataOutRdy,
    output logic [DataWidth-1:0] O_DataOut,
    output logic [1:0]           Dbg_State
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [AddrWidth-1:0] W_CNT = AddrWidth'(W_Words);
    localparam logic [AddrWidth-1:0] I_CNT = AddrWidth'(I_Words);
    localparam logic [AddrWidth-1:0] O_CNT = AddrWidth'(O_Words);

    logic [1:0]           state_q, state_d;
    logic [AddrWidth-1:0] w_ptr_q, w_ptr_d;
    logic [AddrWidth-1:0] i_ptr_q, i_ptr_d;
    logic [AddrWidth-1:0] o_ptr_q, o_ptr_d;
    logic [DataWidth-1:0] w_mem_q [W_Words];
    logic [DataWidth-1:0] w_mem_d [W_Words];
    logic [DataWidth-1:0] i_mem_q [I_Words];
    logic [DataWidth-1:0] i_mem_d [I_Words];
    logic [DataWidth-1:0] o_mem_q [O_Words];
    logic [DataWidth-1:0] o_mem_d [O_Words];

    logic w_valid, i_valid, o_valid;
    logic load_fire;

    // A stream is valid while its pointer has not reached the word count.
    // The pointer saturates there because it only moves on a handshake.
    assign w_valid   = (state_q == ST_SEND) && (w_ptr_q < W_CNT);
    assign i_valid   = (state_q == ST_SEND) && (i_ptr_q < I_CNT);
    assign o_valid   = (state_q == ST_SEND) && (o_ptr_q < O_CNT);
    assign load_fire = Load_Valid && (state_q == ST_IDLE);

    // Load_Rdy is gated by aclr so that every output reads 0 while reset is held.
    assign Load_Rdy       = (state_q == ST_IDLE) && !aclr;
    assign Busy           = (state_q == ST_SEND) || (state_q == ST_DONE);
    assign Done           = (state_q == ST_DONE);
    assign Dbg_State      = state_q;
    assign W_DataOutValid = w_valid;
    assign I_DataOutValid = i_valid;
    assign O_DataOutValid = o_valid;

    // Output read muxes. An index compare per word keeps each buffer at its
    // exact depth and forces the data to zero when the stream is not valid.
    always_comb begin
        W_DataOut = '0;
        I_DataOut = '0;
        O_DataOut = '0;
        for (int k = 0; k < W_Words; k++)
            if (w_valid && (w_ptr_q == AddrWidth'(k))) W_DataOut = w_mem_q[k];
        for (int k = 0; k < I_Words; k++)
            if (i_valid && (i_ptr_q == AddrWidth'(k))) I_DataOut = i_mem_q[k];
        for (int k = 0; k < O_Words; k++)
            if (o_valid && (o_ptr_q == AddrWidth'(k))) O_DataOut = o_mem_q[k];
    end

    // Buffer writes. An address that matches no word is dropped.
    always_comb begin
        w_mem_d = w_mem_q;
        i_mem_d = i_mem_q;
        o_mem_d = o_mem_q;
        if (load_fire) begin
            case (Load_Sel)
                2'd0: for (int k = 0; k < W_Words; k++)
                          if (Load_Addr == AddrWidth'(k)) w_mem_d[k] = Load_Data;
                2'd1: for (int k = 0; k < I_Words; k++)
                          if (Load_Addr == AddrWidth'(k)) i_mem_d[k] = Load_Data;
                2'd2: for (int k = 0; k < O_Words; k++)
                          if (Load_Addr == AddrWidth'(k)) o_mem_d[k] = Load_Data;
                default: ;
            endcase
        end
    end

    // FSM and pointers
    always_comb begin
        state_d = state_q;
        w_ptr_d = w_ptr_q;
        i_ptr_d = i_ptr_q;
        o_ptr_d = o_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_SEND;
                    w_ptr_d = '0;
                    i_ptr_d = '0;
                    o_ptr_d = '0;
                end
            end
            ST_SEND: begin
                if (w_valid && W_DataOutRdy) w_ptr_d = w_ptr_q + 1'b1;
                if (i_valid && I_DataOutRdy) i_ptr_d = i_ptr_q + 1'b1;
                if (o_valid && O_DataOutRdy) o_ptr_d = o_ptr_q + 1'b1;
                if (Abort) begin
                    state_d = ST_IDLE;
                    w_ptr_d = '0;
                    i_ptr_d = '0;
                    o_ptr_d = '0;
                end else if ((w_ptr_d == W_CNT) && (i_ptr_d == I_CNT) &&
                             (o_ptr_d == O_CNT)) begin
                    // Looking at the next pointers lets DONE follow the edge
                    // that carries the last transfer, with no idle cycle in between.
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (Abort) begin
                    w_ptr_d = '0;
                    i_ptr_d = '0;
                    o_ptr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_IDLE;
            w_ptr_q <= '0;
            i_ptr_q <= '0;
            o_ptr_q <= '0;
            for (int k = 0; k < W_Words; k++) w_mem_q[k] <= '0;
            for (int k = 0; k < I_Words; k++) i_mem_q[k] <= '0;
            for (int k = 0; k < O_Words; k++) o_mem_q[k] <= '0;
        end else begin
            state_q <= state_d;
            w_ptr_q <= w_ptr_d;
            i_ptr_q <= i_ptr_d;
            o_ptr_q <= o_ptr_d;
            w_mem_q <= w_mem_d;
            i_mem_q <= i_mem_d;
            o_mem_q <= o_mem_d;
        end
    end

endmodule

// File: tb/tb_pe_group_feeder.sv
// Bench for pe_group_feeder: directed tiles with expected words queued per
// stream, and a negedge monitor that pops and compares on every transfer.
module tb_pe_group_feeder;

    logic        clk;
    logic        aclr;
    logic        Load_Valid;
    logic        Load_Rdy;
    logic [1:0]  Load_Sel;
    logic [4:0]  Load_Addr;
    logic [31:0] Load_Data;
    logic        Start;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic        W_DataOutValid, W_DataOutRdy;
    logic [31:0] W_DataOut;
    logic        I_DataOutValid, I_DataOutRdy;
    logic [31:0] I_DataOut;
    logic        O_DataOutValid, O_DataOutRdy;
    logic [31:0] O_DataOut;
    logic [1:0]  Dbg_State;

    int tests_run = 0;
    int failed    = 0;

    logic [31:0] exp_q [3][$];
    logic        mon_v [3];
    logic        mon_r [3];
    logic [31:0] mon_d [3];
    logic        hold  [3];
    logic [31:0] held  [3];
    string       nm    [3] = '{"W", "I", "O"};

    assign mon_v[0] = W_DataOutValid;
    assign mon_v[1] = I_DataOutValid;
    assign mon_v[2] = O_DataOutValid;
    assign mon_r[0] = W_DataOutRdy;
    assign mon_r[1] = I_DataOutRdy;
    assign mon_r[2] = O_DataOutRdy;
    assign mon_d[0] = W_DataOut;
    assign mon_d[1] = I_DataOut;
    assign mon_d[2] = O_DataOut;

    pe_group_feeder dut (
        .clk(clk), .aclr(aclr),
        .Load_Valid(Load_Valid), .Load_Rdy(Load_Rdy), .Load_Sel(Load_Sel),
        .Load_Addr(Load_Addr), .Load_Data(Load_Data),
        .Start(Start), .Abort(Abort), .Busy(Busy), .Done(Done),
        .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy), .W_DataOut(W_DataOut),
        .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy), .I_DataOut(I_DataOut),
        .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut),
        .Dbg_State(Dbg_State)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected queue on each transfer and checks that a
    // stalled word stays stable and that an idle stream drives zero.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (aclr) begin
                hold[s] = 1'b0;
            end else begin
                if (hold[s]) begin
                    check({nm[s], "_hold_valid"}, {31'd0, mon_v[s]}, 32'd1);
                    check({nm[s], "_hold_data"}, mon_d[s], held[s]);
                end
                if (!mon_v[s]) check({nm[s], "_idle_data"}, mon_d[s], 32'd0);
                if (mon_v[s] && mon_r[s]) begin
                    if (exp_q[s].size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("FAIL %s_unexpected: got %h expected no transfer", nm[s], mon_d[s]);
                    end else begin
                        check({nm[s], "_data"}, mon_d[s], exp_q[s].pop_front());
                    end
                end
                hold[s] = mon_v[s] && !mon_r[s];
                held[s] = mon_d[s];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [1:0] sel, input logic [4:0] addr, input logic [31:0] data);
        Load_Valid = 1'b1;
        Load_Sel   = sel;
        Load_Addr  = addr;
        Load_Data  = data;
        step();
        Load_Valid = 1'b0;
    endtask

    task automatic start_tile();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic push_words(input int s, input logic [31:0] base, input int n, input bit zeros);
        for (int k = 0; k < n; k++) exp_q[s].push_back(zeros ? 32'd0 : base + 32'(k));
    endtask

    task automatic push_tile(input bit zeros);
        push_words(0, 32'h100, 16, zeros);
        push_words(1, 32'h200, 19, zeros);
        push_words(2, 32'h300, 4, zeros);
    endtask

    task automatic check_drained(input string name);
        for (int s = 0; s < 3; s++)
            check({name, "_", nm[s], "_left"}, 32'(exp_q[s].size()), 32'd0);
        for (int s = 0; s < 3; s++) exp_q[s].delete();
    endtask

    // Entered in cycle 1 after the Start edge. Runs until Done, checks the
    // cycle it appeared in, then checks Busy has dropped the cycle after.
    task automatic run_to_done(input string name, input int exp_cycle,
                               input bit toggle_i, input bit spam_load);
        int c;
        bit seen;
        c    = 1;
        seen = 1'b0;
        while (!seen && c <= 200) begin
            I_DataOutRdy = toggle_i ? ((c % 2) == 1) : 1'b1;
            if (spam_load) begin
                Load_Valid = 1'b1;
                Load_Sel   = 2'd0;
                Load_Addr  = 5'd0;
                Load_Data  = 32'hBAD;
            end
            @(negedge clk);
            if (spam_load) check({name, "_load_rdy_busy"}, {31'd0, Load_Rdy}, 32'd0);
            if (Done) seen = 1'b1;
            else begin
                step();
                c++;
            end
        end
        Load_Valid = 1'b0;
        if (!seen) begin
            tests_run++;
            failed++;
            $display("FAIL %s_done_timeout: got no Done expected Done in cycle %0d", name, exp_cycle);
        end else begin
            check({name, "_done_cycle"}, 32'(c), 32'(exp_cycle));
        end
        step();
        I_DataOutRdy = 1'b1;
        check({name, "_busy_after"}, {31'd0, Busy}, 32'd0);
        check({name, "_done_after"}, {31'd0, Done}, 32'd0);
        check_drained(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aclr = 1'b1;
        Load_Valid = 1'b0; Load_Sel = 2'd0; Load_Addr = '0; Load_Data = '0;
        Start = 1'b0; Abort = 1'b0;
        W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            hold[s] = 1'b0;
            held[s] = '0;
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_rdy", {31'd0, Load_Rdy}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_valids", {29'd0, W_DataOutValid, I_DataOutValid, O_DataOutValid}, 32'd0);
        aclr = 1'b0;
        #1;
        check("rst_release_load_rdy", {31'd0, Load_Rdy}, 32'd1);
        check("rst_state", {30'd0, Dbg_State}, 32'd0);
        step();

        // 1: full tile, all ready
        for (int k = 0; k < 16; k++) load_word(2'd0, 5'(k), 32'h100 + 32'(k));
        for (int k = 0; k < 19; k++) load_word(2'd1, 5'(k), 32'h200 + 32'(k));
        for (int k = 0; k < 4; k++)  load_word(2'd2, 5'(k), 32'h300 + 32'(k));
        push_tile(1'b0);
        start_tile();
        run_to_done("t1", 20, 1'b0, 1'b0);

        // 2: I ready toggling 1,0,1,0 -> last I transfer in cycle 37
        push_tile(1'b0);
        start_tile();
        run_to_done("t2", 38, 1'b1, 1'b0);

        // 3: abort raised in cycle 6, after 5 W transfers; cycle 6 still transfers
        push_words(0, 32'h100, 6, 1'b0);
        push_words(1, 32'h200, 6, 1'b0);
        push_words(2, 32'h300, 4, 1'b0);
        start_tile();
        repeat (5) step();
        Abort = 1'b1;
        @(negedge clk);
        check("t3_no_done_abort", {31'd0, Done}, 32'd0);
        step();
        Abort = 1'b0;
        check("t3_valids_off", {29'd0, W_DataOutValid, I_DataOutValid, O_DataOutValid}, 32'd0);
        check("t3_busy_off", {31'd0, Busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_no_done_later", {31'd0, Done}, 32'd0);
            step();
        end
        check_drained("t3");
        push_tile(1'b0);
        start_tile();
        run_to_done("t3_replay", 20, 1'b0, 1'b0);

        // 4: out-of-range and ignored-select loads, then writes attempted during SEND
        load_word(2'd0, 5'd20, 32'hDEAD);
        load_word(2'd3, 5'd0, 32'hFFFF);
        load_word(2'd2, 5'd4, 32'hEEEE);
        push_tile(1'b0);
        start_tile();
        run_to_done("t4", 20, 1'b0, 1'b1);
        push_tile(1'b0);
        start_tile();
        run_to_done("t4_after", 20, 1'b0, 1'b0);

        // 5: W[0] load coincident with Start
        push_tile(1'b0);
        exp_q[0][0] = 32'hABC;
        Load_Valid = 1'b1; Load_Sel = 2'd0; Load_Addr = 5'd0; Load_Data = 32'hABC;
        Start = 1'b1;
        step();
        Load_Valid = 1'b0;
        Start = 1'b0;
        run_to_done("t5", 20, 1'b0, 1'b0);

        // 6: aclr raised mid-cycle 8; transfers in cycles 1..7 complete
        push_words(0, 32'h100, 7, 1'b0);
        exp_q[0][0] = 32'hABC;
        push_words(1, 32'h200, 7, 1'b0);
        push_words(2, 32'h300, 4, 1'b0);
        start_tile();
        repeat (7) step();
        aclr = 1'b1;
        #1;
        check("t6_async_valids", {29'd0, W_DataOutValid, I_DataOutValid, O_DataOutValid}, 32'd0);
        check("t6_async_busy", {31'd0, Busy}, 32'd0);
        check("t6_async_load_rdy", {31'd0, Load_Rdy}, 32'd0);
        step();
        aclr = 1'b0;
        #1;
        check("t6_release_load_rdy", {31'd0, Load_Rdy}, 32'd1);
        check_drained("t6");
        step();
        push_tile(1'b1);
        start_tile();
        run_to_done("t6_zeros", 20, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
